// File: rtl/bin2dec_pkg.sv
// Shared types and decode helper for the binary-to-decimal decoder.
// Latency: n/a (combinational function and constants only).
// Backpressure: n/a.
package bin2dec_pkg;

  localparam int BIN_W = 4;
  localparam int DEC_W = 10;
  localparam logic [BIN_W-1:0] MAX_DIGIT = 4'd9;

  // One buffered result: invalid flag on top, one-hot digit lines below.
  typedef struct packed {
    logic             err;
    logic [DEC_W-1:0] dec;
  } entry_t;

  // Codes 0..9 light exactly one digit line; 10..15 light none and raise err.
  function automatic entry_t decode_bin(input logic [BIN_W-1:0] code);
    entry_t e;
    e = '0;
    if (code <= MAX_DIGIT) begin
      e.dec = DEC_W'(1) << code;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/bin2dec_decoder_fifo2.sv
// Generic 2-entry first-word-fall-through buffer; head entry is presented directly.
// Latency: 1 cycle from push to out_valid when empty; push and pop may share an edge.
// Backpressure: in_ready drops when both entries are full or rst is high; no path from out_ready.
module dec_fifo2 #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_push;
  logic w_pop;

  // in_ready is a function of registered occupancy and rst only.
  assign in_ready  = (r_count != 2'd2) & ~rst;
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Gate the head so the data lines read zero whenever nothing is held.
  assign out_dat = out_valid ? r_mem[r_rd_ptr] : '0;

  // Storage, pointers and occupancy; reset discards everything held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bin2dec_decoder.sv
// Streaming 4-bit binary to one-hot decimal decoder with invalid-code counter.
// Latency: 1 cycle from accepted code to out_valid; 1 code/cycle sustained.
// Backpressure: 2-entry buffer absorbs a downstream stall of two codes, then in_ready drops.
module bin2dec_decoder
  import bin2dec_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIN_W-1:0]     in_bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DEC_W-1:0]     out_dec,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  entry_t               w_entry;
  entry_t               w_head;
  logic                 w_accept;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_entry  = decode_bin(in_bin);
  assign w_accept = in_valid & in_ready;

  dec_fifo2 #(
    .W ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dat    (w_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dat   (w_head)
  );

  assign out_dec   = w_head.dec;
  assign out_err   = w_head.err;
  assign err_count = r_err_count;

  // Count accepted invalid codes, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_accept && w_entry.err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bin2dec_decoder.sv
// Scoreboard bench for bin2dec_decoder plus a narrow-counter instance.
// Latency: n/a.
// Backpressure: exercised through out_ready stalls.
module tb_bin2dec_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_bin;
  logic       out_ready;
  logic       in_ready;
  logic       out_valid;
  logic [9:0] out_dec;
  logic       out_err;
  logic [7:0] err_count;

  logic       in_valid2;
  logic [3:0] in_bin2;
  logic       out_ready2;
  logic       in_ready2;
  logic       out_valid2;
  logic [9:0] out_dec2;
  logic       out_err2;
  logic [1:0] err_count2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic [10:0] exp_q[$];
  logic [10:0] prev_out;
  bit          prev_stall = 1'b0;

  always #5 clk = ~clk;

  bin2dec_decoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec), .out_err(out_err),
    .err_count(err_count)
  );

  bin2dec_decoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_bin(in_bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_dec(out_dec2), .out_err(out_err2),
    .err_count(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode written as a table walk: {err, one-hot digits}.
  function automatic logic [10:0] model(input logic [3:0] c);
    logic [10:0] r;
    r = '0;
    for (int k = 0; k < 10; k++) begin
      if (int'(c) == k) r[k] = 1'b1;
    end
    if (int'(c) >= 10) r[10] = 1'b1;
    return r;
  endfunction

  // Offer one code and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [3:0] c);
    in_valid = 1'b1;
    in_bin   = c;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin   = 4'($urandom);
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: sample between edges, pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (!out_valid) chk("idle_zero", 32'({out_err, out_dec}), 32'd0);
      if (prev_stall) chk("stall_stable", 32'({out_err, out_dec}), 32'(prev_out));
      prev_stall = out_valid & ~out_ready;
      prev_out   = {out_err, out_dec};
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_data", 32'({out_err, out_dec}), 32'(e));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_bin));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_bin     = 4'd0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    in_bin2    = 4'd0;
    out_ready2 = 1'b1;
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_dec", 32'(out_dec), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Stream 0..9 with downstream always ready; each result visible one edge after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(4'(i));
      chk("lat_valid", 32'(out_valid), 32'd1);
      chk("lat_dec", 32'(out_dec), 32'(10'd1 << i));
      chk("lat_err", 32'(out_err), 32'd0);
    end
    idle(2);
    chk("err_cnt_valid_codes", 32'(err_count), 32'd0);

    // Invalid codes are delivered and counted, then a valid code follows.
    for (int i = 10; i < 16; i++) send(4'(i));
    send(4'd3);
    idle(3);
    chk("err_cnt_six", 32'(err_count), 32'd6);

    // Stall: two codes absorbed, the third held off until a pop frees a slot.
    out_ready = 1'b0;
    send(4'd5);
    send(4'd7);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_bin   = 4'd9;
    idle(3);
    chk("held_in_ready", 32'(in_ready), 32'd0);
    chk("held_head", 32'(out_dec), 32'h020);
    out_ready = 1'b1;
    send(4'd9);
    idle(4);

    // Push and pop on the same edge with one entry held.
    out_ready = 1'b0;
    send(4'd2);
    chk("one_head", 32'(out_dec), 32'h004);
    out_ready = 1'b1;
    send(4'd4);
    chk("pp_in_ready", 32'(in_ready), 32'd1);
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_head", 32'(out_dec), 32'h010);
    idle(3);

    // Narrow counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1;
      in_bin2   = 4'(10 + i);
      @(posedge clk);
      #1;
      chk("sat_err_count", 32'(err_count2), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk("sat_out_err", 32'(out_err2), 32'd1);
      chk("sat_out_dec", 32'(out_dec2), 32'd0);
      chk("sat_out_valid", 32'(out_valid2), 32'd1);
      chk("sat_in_ready", 32'(in_ready2), 32'd1);
    end
    in_valid2 = 1'b0;

    // Reset with a full buffer and a pending downstream handshake.
    out_ready = 1'b0;
    send(4'd1);
    send(4'd6);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_dec", 32'(out_dec), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_in_ready2", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);
    idle(4);

    chk("out_total", 32'(n_out), 32'd22);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2dec_decoder.md
# bin2dec_decoder

Streaming 4-bit binary to 10-line one-hot decimal decoder, the inverse of the team's decimal-to-binary encoder. Accepts one binary code per valid/ready transfer, decodes it, and queues the result in a 2-entry output buffer so upstream can keep streaming while downstream stalls. Codes 10..15 are flagged as invalid and counted. It sits on the output side of encode/decode chains, driving one-hot digit lines such as display segment selects or keypad loopback checks.

## Interface
- ERR_CNT_W, 8, width of the saturating invalid-code counter.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bin is valid this cycle.
- in_ready  output  1  decoder can accept a code this cycle.
- in_bin  input  4  binary code 0..15.
- out_valid  output  1  out_dec/out_err hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_dec  output  10  one-hot decimal; bit k set for code k.
- out_err  output  1  current result came from an invalid code (10..15).
- err_count  output  ERR_CNT_W  count of accepted invalid codes, saturating.

## Operation
- Input transfer occurs on a rising edge where in_valid & in_ready. Output transfer occurs on a rising edge where out_valid & out_ready.
- Decode rule for codes 0..9: out_dec = 1 << in_bin and out_err = 0.
- Decode rule for codes 10..15: out_dec = 10'b0 and out_err = 1. The invalid result is still queued and delivered, never dropped.
- Buffer is 2 entries, each 11 bits {err, dec[9:0]}, in FIFO order. The head entry drives out_dec/out_err.
- out_valid = (count != 0). in_ready = (count != 2) & ~rst.
- The count is 0, 1 or 2. Per-edge updates:
  - Push only: count + 1.
  - Pop only: count − 1.
  - Push and pop together with count = 1: count stays 1, new entry becomes the head.
  - At count = 2: in_ready = 0, so no push is possible; a pop takes count to 1.
- err_count increments by 1 on each accepted invalid code. It holds at 2^ERR_CNT_W − 1 and never wraps.
- While out_valid & ~out_ready, out_dec and out_err must stay stable.
- in_bin is ignored when no input transfer occurs.

## Timing
- Reset values: out_valid = 0, out_dec = 0, out_err = 0, err_count = 0, in_ready = 0 while rst is high and 1 in the first cycle after rst falls.
- Latency is 1 cycle. A code accepted at edge N appears on out_dec with out_valid = 1 after edge N, if the buffer was empty.
- Throughput is 1 code per cycle when out_ready is held high.
- A stall absorbs 2 codes. in_ready falls after the edge that fills the second entry and rises after the edge that pops one entry.
- in_ready depends only on registered count and rst, with no combinational path from out_ready. This is a required property.
- err_count updates on the same edge as the accepting transfer.
- Reset mid-operation: on the reset edge, all buffered entries are discarded and err_count is cleared, regardless of pending handshakes.
- No X propagation: out_dec = 0 whenever out_valid = 0.

## Structure
- Package bin2dec_pkg holds:
  - BIN_W = 4, DEC_W = 10, MAX_DIGIT = 9.
  - The entry typedef {err, dec[DEC_W-1:0]}.
  - The pure decode function from code to entry.
- Sub-module dec_fifo2 is a generic 2-entry, first-word-fall-through buffer. It takes the entry width as a parameter and owns count, in_ready and out_valid.
- The top level instantiates dec_fifo2 and adds the decode function and the err_count saturating counter.

## Test plan
- Reset then stream 0..9 with out_ready = 1. Expect out_dec = 001, 002, 004, …, 200 (hex), each 1 cycle after acceptance, with out_err = 0 and err_count = 0.
- Send codes 10..15, then 3. Expect six results with out_dec = 0 and out_err = 1, then out_dec = 10'h008. err_count = 6.
- Hold out_ready = 0 and offer 5, 7, 9. Expect 5 and 7 accepted, then in_ready = 0 and 9 held off. Raise out_ready and expect outputs 020, 080, 200 in order with no loss or duplication.
- With the buffer holding 1 entry, push and pop on the same edge. Expect count to stay 1, the new value at the head next cycle, and in_ready to stay 1.
- With ERR_CNT_W = 2, send 5 invalid codes. Expect err_count = 1, 2, 3, 3, 3.
- Fill the buffer with 2 entries and assert rst for 1 cycle. Expect out_valid = 0, out_dec = 0 and err_count = 0. in_ready = 0 during rst and 1 the cycle after, with no stale entry emitted.
